// File: rtl/poseidon_elem_packer.sv
// Packs a little-endian word stream into field elements for the Poseidon core.
// Double-buffered: the next element assembles while the previous one waits.
module poseidon_elem_packer #(
    parameter int WORD_W = 32,
    parameter int ELEM_W = 255,
    parameter int WORDS  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic              s_last,
    input  logic [WORD_W-1:0] s_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_last,
    output logic [ELEM_W-1:0] m_payload,
    output logic              err_overflow,
    output logic [31:0]       elem_count
);

    localparam int FULL_W = WORD_W * WORDS;
    localparam int IDX_W  = (WORDS > 1) ? $clog2(WORDS) : 1;

    logic [IDX_W-1:0]  word_idx;
    logic [FULL_W-1:0] asm_q;
    logic [FULL_W-1:0] packed_w;
    logic              final_w;
    logic              accept;
    logic              drain;
    logic              load;
    logic              ovf;

    assign final_w = (word_idx == IDX_W'(WORDS - 1)) || s_last;
    // Only a final word needs the output slot, so only it waits on m_ready.
    assign s_ready = !reset && (!final_w || !m_valid || m_ready);
    assign accept  = s_valid && s_ready;
    assign drain   = m_valid && m_ready;
    assign load    = accept && final_w;

    always_comb begin
        packed_w = asm_q;
        packed_w[word_idx*WORD_W +: WORD_W] = s_data;
    end

    generate
        if (FULL_W > ELEM_W) begin : g_ovf
            assign ovf = |packed_w[FULL_W-1:ELEM_W];
        end else begin : g_no_ovf
            assign ovf = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            word_idx     <= '0;
            asm_q        <= '0;
            m_valid      <= 1'b0;
            m_last       <= 1'b0;
            m_payload    <= '0;
            err_overflow <= 1'b0;
            elem_count   <= '0;
        end else begin
            if (accept) begin
                if (final_w) begin
                    word_idx <= '0;
                    asm_q    <= '0;
                end else begin
                    word_idx <= word_idx + IDX_W'(1);
                    asm_q    <= packed_w;
                end
            end
            if (load) begin
                m_payload <= packed_w[ELEM_W-1:0];
                m_last    <= s_last;
                m_valid   <= 1'b1;
                if (ovf) begin
                    err_overflow <= 1'b1;
                end
            end else if (drain) begin
                m_valid <= 1'b0;
            end
            if (drain) begin
                elem_count <= elem_count + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_poseidon_elem_packer.sv
// Scoreboard bench for poseidon_elem_packer: directed scenarios then random traffic.
// A message-level model predicts each element; a negedge monitor compares.
module tb_poseidon_elem_packer;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         s_valid = 1'b0;
    logic         s_ready;
    logic         s_last = 1'b0;
    logic [31:0]  s_data = '0;
    logic         m_valid;
    logic         m_ready = 1'b0;
    logic         m_last;
    logic [254:0] m_payload;
    logic         err_overflow;
    logic [31:0]  elem_count;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int ready_mode = 0;

    typedef struct {
        logic         last;
        logic [254:0] payload;
    } elem_t;

    elem_t       sb[$];
    logic [31:0] wq[$];
    logic        exp_mvalid = 1'b0;
    logic        exp_err = 1'b0;
    logic [31:0] exp_cnt = '0;
    logic        prev_hold = 1'b0;
    logic [254:0] prev_pay;
    logic        prev_last;

    poseidon_elem_packer dut (
        .clk(clk),
        .reset(reset),
        .s_valid(s_valid),
        .s_ready(s_ready),
        .s_last(s_last),
        .s_data(s_data),
        .m_valid(m_valid),
        .m_ready(m_ready),
        .m_last(m_last),
        .m_payload(m_payload),
        .err_overflow(err_overflow),
        .elem_count(elem_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        #1;
        case (ready_mode)
            0: m_ready = 1'b1;
            1: m_ready = 1'b0;
            default: m_ready = ($urandom_range(0, 2) != 0);
        endcase
    end

    function automatic void chk(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Model: an element is the words received since the last boundary,
    // word k at bit 32k, truncated to 255 bits.
    always @(negedge clk) begin
        if (reset) begin
            sb.delete();
            wq.delete();
            exp_mvalid = 1'b0;
            exp_err = 1'b0;
            exp_cnt = '0;
            prev_hold = 1'b0;
        end else begin
            logic load;
            logic exp_sready;
            chk("m_valid", 32'(m_valid), 32'(exp_mvalid));
            chk("err_overflow", 32'(err_overflow), 32'(exp_err));
            chk("elem_count", elem_count, exp_cnt);
            exp_sready = (wq.size() < 7 && !s_last) ? 1'b1 : (!exp_mvalid || m_ready);
            chk("s_ready", 32'(s_ready), 32'(exp_sready));
            if (prev_hold) begin
                checks++;
                if (m_payload !== prev_pay || m_last !== prev_last) begin
                    errors++;
                    $display("FAIL hold_stable: got %h/%0b expected %h/%0b",
                             m_payload, m_last, prev_pay, prev_last);
                end
            end
            if (m_valid && m_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_elem: got %h with empty scoreboard", m_payload);
                end else begin
                    elem_t e;
                    e = sb.pop_front();
                    if (m_payload !== e.payload || m_last !== e.last) begin
                        errors++;
                        $display("FAIL elem: got %h last %0b expected %h last %0b",
                                 m_payload, m_last, e.payload, e.last);
                    end
                end
                exp_cnt = exp_cnt + 1;
            end
            load = 1'b0;
            if (s_valid && s_ready) begin
                wq.push_back(s_data);
                if (s_last || wq.size() == 8) begin
                    logic [255:0] p;
                    elem_t e;
                    p = '0;
                    foreach (wq[k]) p = p | (256'(wq[k]) << (32 * k));
                    e.payload = p[254:0];
                    e.last = s_last;
                    if (p[255]) exp_err = 1'b1;
                    sb.push_back(e);
                    wq.delete();
                    load = 1'b1;
                end
            end
            if (load) exp_mvalid = 1'b1;
            else if (m_valid && m_ready) exp_mvalid = 1'b0;
            prev_hold = m_valid && !m_ready;
            prev_pay = m_payload;
            prev_last = m_last;
        end
    end

    task automatic send_word(input logic [31:0] d, input logic l);
        int n;
        bit done;
        n = 0;
        done = 1'b0;
        s_valid = 1'b1;
        s_data = d;
        s_last = l;
        while (!done) begin
            @(negedge clk);
            done = s_ready;
            @(posedge clk);
            #1;
            n++;
            if (!done && n > 300) begin
                checks++;
                errors++;
                $display("FAIL send_timeout: got no s_ready expected handshake");
                done = 1'b1;
            end
        end
        s_valid = 1'b0;
        s_last = 1'b0;
        s_data = $urandom;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        int c0;
        idle(3);
        reset = 1'b0;
        @(negedge clk);
        chk("reset_payload", 32'(m_payload[31:0]), 32'h0);
        chk("reset_last", 32'(m_last), 32'h0);
        @(posedge clk);
        #1;

        ready_mode = 0;
        for (int i = 1; i <= 8; i++) send_word(32'(i), i == 8);
        idle(3);

        send_word(32'hA, 1'b0);
        send_word(32'hB, 1'b0);
        send_word(32'hC, 1'b1);
        idle(3);

        ready_mode = 1;
        idle(1);
        for (int i = 0; i < 15; i++) send_word(32'h100 + 32'(i), 1'b0);
        s_valid = 1'b1;
        s_data = 32'h10F;
        s_last = 1'b1;
        idle(2);
        @(negedge clk);
        chk("s_ready_blocked", 32'(s_ready), 32'h0);
        ready_mode = 0;
        send_word(32'h10F, 1'b1);
        idle(4);

        for (int i = 0; i < 8; i++)
            send_word(i == 7 ? 32'h8000_0001 : 32'h55 + 32'(i), i == 7);
        idle(3);
        send_word(32'h1234, 1'b1);
        idle(3);

        for (int i = 0; i < 5; i++) send_word(32'h200 + 32'(i), 1'b0);
        pulse_reset();
        for (int i = 0; i < 8; i++) send_word(32'h300 + 32'(i), i == 7);
        idle(3);
        ready_mode = 1;
        idle(1);
        for (int i = 0; i < 8; i++) send_word(32'h400 + 32'(i), i == 7);
        idle(3);
        pulse_reset();
        ready_mode = 0;
        idle(3);

        c0 = cyc;
        for (int i = 0; i < 32; i++) send_word($urandom, (i % 8) == 7);
        chk("full_rate_cycles", 32'(cyc - c0), 32'd32);
        idle(3);

        ready_mode = 2;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) idle(1);
            send_word($urandom, $urandom_range(0, 5) == 0);
        end
        ready_mode = 0;
        idle(10);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
